// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem request/grant/response, holds the word for decode.
// Optional macro IFETCH_STALL_CNT_EN builds a saturating fetch-wait counter on stall_cnt.
module instr_fetch #(
   parameter int BITS = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic [BITS-1:0] pc_addr,
   output logic            load_instr,
   output logic            imem_req,
   output logic [BITS-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [BITS-1:0] imem_rdata,
   output logic [BITS-1:0] instr,
   output logic [BITS-1:0] instr_pc,
   output logic            instr_valid,
   input  logic            decode_ready,
   output logic [31:0]     stall_cnt
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t          state_q;
   logic [BITS-1:0] req_pc_q;
   logic [BITS-1:0] instr_q;
   logic [BITS-1:0] instr_pc_q;
   logic            instr_valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         req_pc_q      <= '0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         instr_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (run) state_q <= REQ;
            end
            REQ: begin
               // A grant wins over a late run drop: once accepted, the response must be collected.
               if (imem_gnt) begin
                  req_pc_q <= pc_addr;
                  state_q  <= WAIT;
               end else if (!run) begin
                  state_q <= IDLE;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  instr_q       <= imem_rdata;
                  instr_pc_q    <= req_pc_q;
                  instr_valid_q <= 1'b1;
                  state_q       <= HOLD;
               end
            end
            HOLD: begin
               if (decode_ready) begin
                  instr_valid_q <= 1'b0;
                  state_q       <= run ? REQ : IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign imem_req    = (state_q == REQ);
   assign imem_addr   = imem_req ? pc_addr : '0;
   assign load_instr  = (state_q == HOLD) && decode_ready;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;

`ifdef IFETCH_STALL_CNT_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] stall_cnt_d;
   logic        stall_cyc;

   assign stall_cyc = ((state_q == REQ) && !imem_gnt) || ((state_q == WAIT) && !imem_rvalid);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_cyc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then random traffic, scored against a
// transaction-level model of the fetch protocol (pending request, outstanding read, held word).
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic        run;
   logic [31:0] pc_addr;
   logic        load_instr;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        decode_ready;
   logic [31:0] stall_cnt;

`ifdef IFETCH_STALL_CNT_EN
   localparam logic STALL_ON = 1'b1;
   localparam logic [31:0] STALL5 = 32'd5;
`else
   localparam logic STALL_ON = 1'b0;
   localparam logic [31:0] STALL5 = 32'd0;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int loads  = 0;

   // reference model state
   logic        exp_req;
   logic        outst;
   logic [31:0] out_addr;
   logic        exp_valid;
   logic [31:0] exp_instr;
   logic [31:0] exp_pc;
   logic [31:0] exp_stall;
   logic        rand_pc;

   // per-tick samples for directed checks
   logic        s_req, s_load, s_valid;
   logic [31:0] s_addr, s_instr, s_pc;

   int          req_cyc[$];
   logic [31:0] req_a[$];
   logic [31:0] ld_pc[$];

   instr_fetch #(.BITS(32)) dut (
      .clk(clk), .rst(rst), .run(run), .pc_addr(pc_addr), .load_instr(load_instr),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
      .instr_pc(instr_pc), .instr_valid(instr_valid), .decode_ready(decode_ready),
      .stall_cnt(stall_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_req   = 1'b0;
      outst     = 1'b0;
      out_addr  = '0;
      exp_valid = 1'b0;
      exp_instr = '0;
      exp_pc    = '0;
      exp_stall = '0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk1({tag, "_req"},   imem_req, 1'b0);
      chk32({tag, "_addr"}, imem_addr, 32'h0);
      chk32({tag, "_instr"}, instr, 32'h0);
      chk32({tag, "_pc"},   instr_pc, 32'h0);
      chk1({tag, "_valid"}, instr_valid, 1'b0);
      chk1({tag, "_load"},  load_instr, 1'b0);
      chk32({tag, "_stall"}, stall_cnt, 32'h0);
   endtask

   // One clock: drive memory/decode at negedge, check against model, advance model, step edge.
   task automatic tick(input logic g, input logic rv, input logic dr, input logic [31:0] data);
      logic free, loaded, nxt_req;
      @(negedge clk);
      imem_gnt     = g;
      imem_rvalid  = rv;
      imem_rdata   = data;
      decode_ready = dr;
      #1;
      s_req = imem_req;  s_load = load_instr; s_addr = imem_addr;
      s_valid = instr_valid; s_instr = instr; s_pc = instr_pc;
      chk1("imem_req", imem_req, exp_req);
      chk32("imem_addr", imem_addr, exp_req ? pc_addr : 32'h0);
      chk1("instr_valid", instr_valid, exp_valid);
      chk32("instr", instr, exp_instr);
      chk32("instr_pc", instr_pc, exp_pc);
      chk1("load_instr", load_instr, exp_valid && dr);
      chk32("stall_cnt", stall_cnt, exp_stall);

      free    = !outst && !exp_valid;
      loaded  = exp_valid && dr;
      nxt_req = run && ((free && !(exp_req && g)) || loaded);
      if (STALL_ON && ((exp_req && !g) || (outst && !rv)) && exp_stall != 32'hFFFF_FFFF)
         exp_stall = exp_stall + 32'd1;
      if (loaded) begin
         exp_valid = 1'b0;
         loads++;
      end
      if (exp_req && g) begin
         outst    = 1'b1;
         out_addr = pc_addr;
      end else if (outst && rv) begin
         outst     = 1'b0;
         exp_valid = 1'b1;
         exp_instr = data;
         exp_pc    = out_addr;
      end
      exp_req = nxt_req;
      cyc++;
      @(posedge clk);
      #1;
      if (loaded) pc_addr = rand_pc ? $urandom : pc_addr + 32'd1;
   endtask

   initial begin
      logic any_load;
      rst = 1'b1; run = 1'b0; pc_addr = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
      imem_rdata = '0; decode_ready = 1'b0; rand_pc = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("rst");

      // zero-wait fetch of 0x10
      rst = 1'b0; run = 1'b1; pc_addr = 32'h10;
      tick(1'b0, 1'b0, 1'b1, 32'h0);
      chk1("t1_idle_cycle", s_req, 1'b0);
      tick(1'b1, 1'b0, 1'b1, 32'h0);
      chk1("t1_req", s_req, 1'b1);
      chk32("t1_addr", s_addr, 32'h10);
      tick(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
      chk1("t1_wait_noreq", s_req, 1'b0);
      tick(1'b0, 1'b0, 1'b1, 32'h0);
      chk32("t1_instr", s_instr, 32'hDEAD_BEEF);
      chk32("t1_instr_pc", s_pc, 32'h10);
      chk1("t1_valid", s_valid, 1'b1);
      chk1("t1_load", s_load, 1'b1);

      // grant after 3 stalls, data after 2 more
      any_load = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick((i == 3) ? 1'b1 : 1'b0, 1'b0, 1'b0, 32'h0);
         chk1("t2_req_stable", s_req, 1'b1);
         chk32("t2_addr_stable", s_addr, 32'h11);
         any_load |= s_load;
      end
      tick(1'b0, 1'b0, 1'b0, 32'h0); any_load |= s_load;
      tick(1'b0, 1'b0, 1'b0, 32'h0); any_load |= s_load;
      tick(1'b0, 1'b1, 1'b0, 32'hCAFE_0011); any_load |= s_load;
      chk1("t2_no_load", any_load, 1'b0);

      // hold with decode stalled
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 1'b0, 1'b0, 32'h0);
         chk1("t3_valid_held", s_valid, 1'b1);
         chk32("t3_instr_held", s_instr, 32'hCAFE_0011);
         chk1("t3_no_load", s_load, 1'b0);
      end
      chk32("t2_stall_total", stall_cnt, STALL5);
      tick(1'b0, 1'b0, 1'b1, 32'h0);
      chk1("t3_load", s_load, 1'b1);
      tick(1'b1, 1'b0, 1'b1, 32'h0);
      chk1("t3_load_single", s_load, 1'b0);
      chk32("t3_next_addr", s_addr, 32'h12);

      // run dropped while waiting for data
      run = 1'b0;
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b1, 1'b0, 32'h1234_5678);
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      chk32("t4_instr", s_instr, 32'h1234_5678);
      chk32("t4_instr_pc", s_pc, 32'h12);
      tick(1'b0, 1'b0, 1'b1, 32'h0);
      chk1("t4_load", s_load, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b1, 1'b1, $urandom);
         chk1("t4_parked", s_req, 1'b0);
      end

      // reset while waiting, stale rvalid after release
      run = 1'b1;
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      #1;
      model_reset();
      chk_reset_vals("t5_rst");
      @(posedge clk);
      #1;
      rst = 1'b0; run = 1'b0;
      tick(1'b0, 1'b1, 1'b0, 32'hBAD0_BAD0);
      tick(1'b0, 1'b0, 1'b0, 32'h0);
      chk1("t5_valid", s_valid, 1'b0);
      chk32("t5_instr", s_instr, 32'h0);

      // back-to-back zero-wait fetches
      pc_addr = 32'h0; run = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick(1'b1, 1'b1, 1'b1, 32'hB2B0_0000 | pc_addr);
         if (s_req) begin req_cyc.push_back(cyc); req_a.push_back(s_addr); end
         if (s_load) ld_pc.push_back(s_pc);
      end
      chk1("t6_enough", (req_cyc.size() >= 3) && (ld_pc.size() >= 3), 1'b1);
      if (req_cyc.size() >= 3 && ld_pc.size() >= 3) begin
         for (int i = 0; i < 3; i++) begin
            chk32("t6_req_addr", req_a[i], 32'(i));
            chk32("t6_instr_pc", ld_pc[i], 32'(i));
         end
         chk32("t6_spacing1", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
         chk32("t6_spacing2", 32'(req_cyc[2] - req_cyc[1]), 32'd3);
      end

      // random traffic
      rand_pc = 1'b1;
      loads = 0;
      for (int i = 0; i < 400; i++) begin
         run = ($urandom_range(0, 9) != 0);
         tick(1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      end
      chk1("rand_progress", loads > 10, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly downstream of the program counter. Each cycle it samples `pc_addr`, fetches one word from instruction memory over a request/grant/response handshake, and holds the instruction for decode. It pulses `load_instr` to advance the program counter once decode consumes the instruction. Exactly one memory transaction is outstanding at a time.

## Interface
- `BITS`, 32, word width; applies to addresses and instructions.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  fetch enable; 0 parks the block in IDLE after any in-flight fetch completes.
- `pc_addr`  in  BITS  current word address from the program counter.
- `load_instr`  out  1  advance pulse to the program counter; combinational `(state==HOLD) && decode_ready`.
- `imem_req`  out  1  memory request.
- `imem_addr`  out  BITS  request address; equals `pc_addr` while `imem_req` is 1.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  read data valid.
- `imem_rdata`  in  BITS  read data.
- `instr`  out  BITS  held instruction.
- `instr_pc`  out  BITS  address the held instruction was fetched from.
- `instr_valid`  out  1  `instr` and `instr_pc` are valid for decode.
- `decode_ready`  in  1  decode consumes the instruction this cycle.
- `stall_cnt`  out  32  fetch-wait cycle counter; see Configuration.

## Operation
- State machine: IDLE, REQ, WAIT, HOLD. Reset state is IDLE.
- IDLE: `imem_req`=0. If `run`=1, go to REQ on the next edge.
- REQ: `imem_req`=1 and `imem_addr`=`pc_addr`.
  - On `imem_gnt`=1, capture `req_pc <= pc_addr` and go to WAIT.
  - Request and address stay stable until grant.
  - If `run` drops before grant, drop the request and go to IDLE. This is legal only because nothing has been accepted yet.
- WAIT: `imem_req`=0. On `imem_rvalid`=1: `instr <= imem_rdata`, `instr_pc <= req_pc`, `instr_valid <= 1`, go to HOLD. `run` is ignored; the response is always collected.
- HOLD: `instr_valid`=1. While `decode_ready`=0, hold all outputs.
  - On `decode_ready`=1, `load_instr`=1 for that cycle and the PC loads its next address on the same edge.
  - Next state is REQ if `run`=1, else IDLE. `instr_valid` clears on that edge.
- `imem_gnt` outside REQ and `imem_rvalid` outside WAIT are ignored. This covers stale responses arriving after reset.
- `load_instr` is 0 in every state except HOLD with `decode_ready`=1. The PC therefore never advances without a consumed instruction.
- Address arithmetic is not performed here; no wrap logic is needed. `pc_addr` is passed through unmodified, including `{BITS{1'b1}}`.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `load_instr`=0, `stall_cnt`=0, state=IDLE.
- Reset asserted mid-transaction returns to IDLE immediately and abandons the outstanding fetch.
- Minimum latency with zero-wait memory:
  - REQ with grant, cycle 0.
  - WAIT with rvalid, cycle 1.
  - HOLD with `instr_valid`=1, cycle 2.
  - `decode_ready` in cycle 2 gives `load_instr` in cycle 2 and the next REQ in cycle 3.
- Peak throughput is one instruction per 3 cycles.
- `imem_rvalid` is earliest the cycle after `imem_gnt`. Same-cycle grant and data is not supported.
- First fetch after `rst` deasserts with `run`=1: IDLE for one cycle, then REQ.

## Configuration
- `IFETCH_STALL_CNT_EN` defined: `stall_cnt` increments by 1 every cycle the state is REQ without grant, or WAIT without rvalid. It saturates at 32'hFFFF_FFFF and resets to 0 on `rst`.
- Undefined: `stall_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Reset, then `run`=1, `pc_addr`=0x10, zero-wait memory returning 0xDEADBEEF, `decode_ready`=1 → `imem_addr`=0x10, then `instr`=0xDEADBEEF, `instr_pc`=0x10, `instr_valid`=1 two cycles after REQ, and a single-cycle `load_instr`.
- Grant delayed 3 cycles and rvalid delayed 2 more → `imem_req` and `imem_addr` stable for 4 cycles, `load_instr` stays 0 throughout, and `stall_cnt`=5 with the macro defined (0 without).
- HOLD with `decode_ready`=0 for 4 cycles, then 1 → `instr` and `instr_valid` held, exactly one `load_instr` pulse, and the next request uses the updated `pc_addr`.
- `run` deasserted in WAIT → the response is still captured and consumed, then the block parks in IDLE with `imem_req`=0.
- `rst` asserted in WAIT, with `imem_rvalid`=1 arriving 1 cycle after release → the response is ignored, `instr_valid`=0, and all outputs hold their reset values.
- Back-to-back fetches at `pc_addr` 0x0, 0x1, 0x2 with `decode_ready` tied to 1 → requests spaced 3 cycles apart and `instr_pc` sequence 0x0, 0x1, 0x2.
